// File: rtl/fc_layer_seq_if.sv
// Stream and bus signals of fc_layer_seq: serial activations in, x/z buses to the layer array,
// serial results out. Argmax outputs exist only with FC_LAYER_SEQ_ARGMAX_EN.
interface fc_layer_seq_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned IN    = 128,
    parameter int unsigned N_OUT = 10,
    parameter int unsigned ACC_W = 23
);
    localparam int unsigned IDX_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;

    logic                   start;
    logic                   in_valid;
    logic                   in_ready;
    logic [WIDTH-1:0]       in_data;
    logic                   in_last;
    logic [IN*WIDTH-1:0]    x_bus;
    logic [N_OUT*ACC_W-1:0] z_bus;
    logic                   out_valid;
    logic                   out_ready;
    logic [ACC_W-1:0]       out_data;
    logic [IDX_W-1:0]       out_idx;
    logic                   out_last;
    logic                   busy;
    logic                   short_frame;
`ifdef FC_LAYER_SEQ_ARGMAX_EN
    logic [IDX_W-1:0]       argmax_idx;
    logic                   argmax_valid;

    modport master (
        input  start, in_valid, in_data, in_last, z_bus, out_ready,
        output in_ready, x_bus, out_valid, out_data, out_idx, out_last, busy, short_frame,
        output argmax_idx, argmax_valid
    );
    modport slave (
        output start, in_valid, in_data, in_last, z_bus, out_ready,
        input  in_ready, x_bus, out_valid, out_data, out_idx, out_last, busy, short_frame,
        input  argmax_idx, argmax_valid
    );
`else
    modport master (
        input  start, in_valid, in_data, in_last, z_bus, out_ready,
        output in_ready, x_bus, out_valid, out_data, out_idx, out_last, busy, short_frame
    );
    modport slave (
        output start, in_valid, in_data, in_last, z_bus, out_ready,
        input  in_ready, x_bus, out_valid, out_data, out_idx, out_last, busy, short_frame
    );
`endif
endinterface

// File: rtl/fc_layer_seq.sv
// Sequencer for a combinational FC layer array: load activations, settle, snapshot, drain.
// Optional registered argmax of the snapshot when FC_LAYER_SEQ_ARGMAX_EN is defined.
module fc_layer_seq #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned IN     = 128,
    parameter int unsigned N_OUT  = 10,
    parameter int unsigned ACC_W  = 23,
    parameter int unsigned SETTLE = 2
) (
    input logic         clk,
    input logic         rst_n,
    fc_layer_seq_if.master bus
);
    localparam int unsigned CNT_W = $clog2(IN + 1);
    localparam int unsigned IDX_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;

    localparam logic [2:0] StIdle    = 3'd0;
    localparam logic [2:0] StLoad    = 3'd1;
    localparam logic [2:0] StSettle  = 3'd2;
    localparam logic [2:0] StCapture = 3'd3;
    localparam logic [2:0] StDrain   = 3'd4;

    logic [2:0]             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q;
    logic [3:0]             timer_q;
    logic [IDX_W-1:0]       idx_q;
    logic [IN*WIDTH-1:0]    buf_q;
    logic [N_OUT*ACC_W-1:0] snap_q;
    logic                   short_q;

    logic accept, last_word, out_fire, idx_end;

    assign accept    = (state_q == StLoad) && bus.in_valid;
    assign last_word = (cnt_q == CNT_W'(IN - 1));
    assign out_fire  = (state_q == StDrain) && bus.out_ready;
    assign idx_end   = (idx_q == IDX_W'(N_OUT - 1));

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (bus.start) state_d = StLoad;
            StLoad:    if (accept && (last_word || bus.in_last)) state_d = StSettle;
            StSettle:  if (timer_q == 4'(SETTLE - 1)) state_d = StCapture;
            StCapture: state_d = StDrain;
            StDrain:   if (out_fire && idx_end) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            timer_q <= '0;
            idx_q   <= '0;
            buf_q   <= '0;
            snap_q  <= '0;
            short_q <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        buf_q   <= '0;
                        short_q <= 1'b0;
                        cnt_q   <= '0;
                    end
                end
                StLoad: begin
                    timer_q <= '0;
                    if (accept) begin
                        buf_q[cnt_q*WIDTH +: WIDTH] <= bus.in_data;
                        cnt_q                       <= cnt_q + CNT_W'(1);
                        if (bus.in_last && !last_word) short_q <= 1'b1;
                    end
                end
                StSettle: timer_q <= timer_q + 4'd1;
                StCapture: begin
                    snap_q <= bus.z_bus;
                    idx_q  <= '0;
                end
                StDrain: begin
                    if (out_fire) idx_q <= idx_end ? '0 : idx_q + IDX_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready    = (state_q == StLoad);
    assign bus.x_bus       = buf_q;
    assign bus.out_valid   = (state_q == StDrain);
    assign bus.out_data    = snap_q[idx_q*ACC_W +: ACC_W];
    assign bus.out_idx     = idx_q;
    assign bus.out_last    = (state_q == StDrain) && idx_end;
    assign bus.busy        = (state_q != StIdle);
    assign bus.short_frame = short_q;

`ifdef FC_LAYER_SEQ_ARGMAX_EN
    logic [IDX_W-1:0] am_idx_d, am_idx_q;
    logic [ACC_W-1:0] am_max;
    logic             am_valid_q;

    // Strict > keeps the lowest index on ties; z_bus equals the snapshot being latched.
    always_comb begin
        am_idx_d = '0;
        am_max   = bus.z_bus[0 +: ACC_W];
        for (int j = 1; j < int'(N_OUT); j++) begin
            if (bus.z_bus[j*ACC_W +: ACC_W] > am_max) begin
                am_max   = bus.z_bus[j*ACC_W +: ACC_W];
                am_idx_d = IDX_W'(j);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            am_idx_q   <= '0;
            am_valid_q <= 1'b0;
        end else begin
            am_valid_q <= (state_q == StCapture);
            if (state_q == StCapture) am_idx_q <= am_idx_d;
        end
    end

    assign bus.argmax_idx   = am_idx_q;
    assign bus.argmax_valid = am_valid_q;
`endif
endmodule

// File: tb/tb_fc_layer_seq.sv
// Randomized bench for fc_layer_seq against a frame-level behavioural model.
module tb_fc_layer_seq;
    localparam int WIDTH  = 8;
    localparam int IN     = 128;
    localparam int N_OUT  = 10;
    localparam int ACC_W  = 23;
    localparam int SETTLE = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fc_layer_seq_if #(.WIDTH(WIDTH), .IN(IN), .N_OUT(N_OUT), .ACC_W(ACC_W)) bus ();

    fc_layer_seq #(
        .WIDTH (WIDTH),
        .IN    (IN),
        .N_OUT (N_OUT),
        .ACC_W (ACC_W),
        .SETTLE(SETTLE)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Layer array stand-in: random results every cycle unless held.
    logic                   z_hold = 1'b0;
    logic [N_OUT*ACC_W-1:0] z_fixed = '0;
    always @(posedge clk) begin
        #1;
        if (z_hold) bus.z_bus = z_fixed;
        else for (int j = 0; j < N_OUT; j++) bus.z_bus[j*ACC_W +: ACC_W] = ACC_W'($urandom);
    end

    // Frame-level model: phase 0 idle, 1 loading, 2 waiting for capture, 3 draining.
    int               m_phase, m_wait, m_cnt, m_idx, m_am, m_short, m_first;
    int               cyc = 0, acc_cyc = 0;
    logic [WIDTH-1:0] m_buf[IN];
    logic [ACC_W-1:0] m_snap[N_OUT];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0; m_wait = 0; m_cnt = 0; m_idx = 0; m_am = 0; m_short = 0; m_first = 0;
            foreach (m_buf[i]) m_buf[i] = '0;
            foreach (m_snap[i]) m_snap[i] = '0;
        end else begin
            cyc++;
            case (m_phase)
                0: if (bus.start) begin
                    foreach (m_buf[i]) m_buf[i] = '0;
                    m_short = 0; m_cnt = 0; m_phase = 1;
                end
                1: if (bus.in_valid) begin
                    m_buf[m_cnt] = bus.in_data;
                    if (m_cnt == IN - 1 || bus.in_last) begin
                        if (m_cnt < IN - 1) m_short = 1;
                        m_phase = 2; m_wait = SETTLE + 1; acc_cyc = cyc;
                    end
                    m_cnt++;
                end
                2: begin
                    m_wait--;
                    if (m_wait == 0) begin
                        m_am = 0;
                        for (int j = 0; j < N_OUT; j++) begin
                            m_snap[j] = bus.z_bus[j*ACC_W +: ACC_W];
                            if (m_snap[j] > m_snap[m_am]) m_am = j;
                        end
                        m_idx = 0; m_first = 1; m_phase = 3;
                    end
                end
                default: begin
                    m_first = 0;
                    if (bus.out_ready) begin
                        if (m_idx == N_OUT - 1) begin m_phase = 0; m_idx = 0; end
                        else m_idx++;
                    end
                end
            endcase
        end
    end

    logic             ov_prev = 1'b0;
    logic [ACC_W-1:0] d1 = '0;
    int               am_pulses = 0, am_seen = -1;

    always @(negedge clk) begin
        int k;
        chk("busy", bus.busy, m_phase != 0);
        chk("in_ready", bus.in_ready, m_phase == 1);
        chk("out_valid", bus.out_valid, m_phase == 3);
        chk("short_frame", bus.short_frame, m_short != 0);
        chk("out_last", bus.out_last, m_phase == 3 && m_idx == N_OUT - 1);
        if (m_phase == 3) begin
            chk("out_data", bus.out_data, m_snap[m_idx]);
            chk("out_idx", bus.out_idx, m_idx);
        end
        k = cyc % IN;
        for (int i = IN - 1; i >= 0; i--) if (bus.x_bus[i*WIDTH +: WIDTH] !== m_buf[i]) k = i;
        chk($sformatf("x_bus[%0d]", k), bus.x_bus[k*WIDTH +: WIDTH], m_buf[k]);
        if (bus.out_valid && !ov_prev) chk("latency", cyc + 1 - acc_cyc, SETTLE + 2);
        ov_prev = bus.out_valid;
        if (bus.out_valid && bus.out_idx == 1) d1 = bus.out_data;
`ifdef FC_LAYER_SEQ_ARGMAX_EN
        chk("argmax_valid", bus.argmax_valid, m_phase == 3 && m_first != 0);
        if (m_phase == 3 && m_first != 0) chk("argmax_idx", bus.argmax_idx, m_am);
        if (bus.argmax_valid) begin am_pulses++; am_seen = int'(bus.argmax_idx); end
`endif
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // mode 0: word k = k&0x7F, else random. gap 0 none, 1 alternate, 2 random. bp 1: 1,0,0,1 ready.
    task automatic run_frame(input int last_at, input int gap, input int bp, input int mode,
                             input int abort_at);
        logic [WIDTH-1:0] w[IN];
        int               k, g;
        logic             fire;
        for (int i = 0; i < IN; i++) w[i] = (mode == 0) ? WIDTH'(i & 'h7F) : WIDTH'($urandom);
        bus.start = 1'b1; bus.in_valid = 1'b1; bus.in_data = w[0]; bus.in_last = (last_at == 0);
        step();
        bus.start = 1'b0;
        k = 0; g = 0;
        while (k <= last_at && g < 4 * IN + 50) begin
            if (k == abort_at) begin
                rst_n = 1'b0;
                #1;
                chk("rst_busy", bus.busy, 1'b0);
                chk("rst_in_ready", bus.in_ready, 1'b0);
                chk("rst_x_bus_zero", {63'd0, |bus.x_bus}, 64'd0);
                bus.in_valid = 1'b0; bus.in_last = 1'b0;
                step();
                rst_n = 1'b1;
                step();
                return;
            end
            if (gap == 0) bus.in_valid = 1'b1;
            else if (gap == 1) bus.in_valid = (g % 2 == 0);
            else bus.in_valid = 1'($urandom);
            bus.in_data = w[k];
            bus.in_last = (k == last_at);
            bus.start   = (gap != 0 && k == 10);
            fire = bus.in_valid && bus.in_ready;
            step();
            if (fire) k++;
            g++;
        end
        bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.start = 1'b0;
        if (k <= last_at) chk("load_timeout", k, last_at + 1);
        g = 0;
        while (bus.busy && g < 500) begin
            bus.out_ready = (bp == 0) ? 1'b1 : (g % 4 == 0 || g % 4 == 3);
            step();
            g++;
        end
        bus.out_ready = 1'b1;
        if (bus.busy) chk("drain_timeout", bus.busy, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        bus.start = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0; bus.in_last = 1'b0;
        bus.out_ready = 1'b1;
        step(); step();
        chk("reset_out_valid", bus.out_valid, 1'b0);
        chk("reset_out_data", bus.out_data, 0);
        chk("reset_out_idx", bus.out_idx, 0);
        chk("reset_busy", bus.busy, 1'b0);
        chk("reset_x_bus_zero", {63'd0, |bus.x_bus}, 64'd0);
        rst_n = 1'b1;
        step();

        run_frame(IN - 1, 0, 0, 0, -1);
        chk("frame1_x5", bus.x_bus[5*WIDTH +: WIDTH], 5);
        chk("frame1_x127", bus.x_bus[127*WIDTH +: WIDTH], 127);
        chk("frame1_short", bus.short_frame, 1'b0);

        run_frame(40, 0, 1, 1, -1);
        chk("short_set", bus.short_frame, 1'b1);
        chk("short_x41", bus.x_bus[41*WIDTH +: WIDTH], 0);

        run_frame(IN - 1, 0, 1, 1, -1);
        chk("short_cleared", bus.short_frame, 1'b0);

        run_frame(IN - 1, 1, 0, 1, -1);
        run_frame(IN - 1, 0, 0, 1, 60);
        chk("after_rst_busy", bus.busy, 1'b0);
        run_frame(IN - 1, 0, 0, 0, -1);
        chk("after_rst_x100", bus.x_bus[100*WIDTH +: WIDTH], 100);

        for (int r = 0; r < 6; r++)
            run_frame(($urandom % 3 == 0) ? int'($urandom_range(0, IN - 2)) : IN - 1,
                      int'($urandom % 3), int'($urandom % 2), 1, -1);

        z_fixed = '0;
        z_fixed[0*ACC_W +: ACC_W] = ACC_W'(5);
        z_fixed[1*ACC_W +: ACC_W] = ACC_W'(9);
        z_fixed[2*ACC_W +: ACC_W] = ACC_W'(9);
        z_hold = 1'b1;
        p0 = am_pulses;
        run_frame(IN - 1, 0, 1, 1, -1);
        z_hold = 1'b0;
        chk("held_z_idx1", d1, 9);
`ifdef FC_LAYER_SEQ_ARGMAX_EN
        chk("argmax_literal", am_seen, 1);
        chk("argmax_one_pulse", am_pulses - p0, 1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
